// File: rtl/uc_atende_fila.sv
// uc_atende_fila: lift service controller. It walks the car one floor at a time toward the
//   top entry of the request RAM and re-reads that entry after each floor. At the target it
//   opens the door, then pops the entry.
// Latency: each floor moved costs T_ANDAR+3 cycles. When the car is already at the target,
//   pop follows the top read after T_PORTA+3 cycles.
// Backpressure: the unit holds in LE_TOPO while the queue is empty or the insertion unit is
//   busy, and holds in ESPERA_REMOVE while insertion is busy. pop never overlaps an insertion.
// Ports:
//   clock, reset                 rising-edge clock; synchronous active-low reset
//   iniciar                      level enable, sampled only in OCIOSO / LE_TOPO
//   fila_vazia, andar_alvo       request-queue status and the floor in its top entry
//   ocupado_insercao             insertion unit is modifying the RAM
//   andar_atual                  registered car floor
//   sobe, desce, porta_aberta    motor up/down and door drive
//   pop, chegou, erro            one-cycle pulses: remove top, arrived, bad target dropped
//   Eatual_db                    current state code
module uc_atende_fila #(
  parameter int W_ANDAR   = 4,
  parameter int N_ANDARES = 8,
  parameter int T_ANDAR   = 50,
  parameter int T_PORTA   = 100
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               fila_vazia,
  input  logic [W_ANDAR-1:0] andar_alvo,
  input  logic               ocupado_insercao,
  output logic [W_ANDAR-1:0] andar_atual,
  output logic               sobe,
  output logic               desce,
  output logic               porta_aberta,
  output logic               pop,
  output logic               chegou,
  output logic               erro,
  output logic [3:0]         Eatual_db
);

  typedef enum logic [3:0] {
    OCIOSO        = 4'd0,
    LE_TOPO       = 4'd1,
    COMPARA       = 4'd2,
    SOBE          = 4'd3,
    DESCE         = 4'd4,
    ATUALIZA      = 4'd5,
    PORTA         = 4'd6,
    ESPERA_REMOVE = 4'd7,
    POP           = 4'd8,
    DESCARTA      = 4'd9
  } estado_t;

  localparam int T_MAX = (T_ANDAR > T_PORTA) ? T_ANDAR : T_PORTA;
  localparam int TW    = $clog2(T_MAX) + 1;
  localparam int WL    = W_ANDAR + 1;
  localparam logic [TW-1:0] FIM_ANDAR = TW'(T_ANDAR - 1);
  localparam logic [TW-1:0] FIM_PORTA = TW'(T_PORTA - 1);
  // One extra bit so that N_ANDARES == 2**W_ANDAR still compares correctly.
  localparam logic [WL-1:0] LIMITE    = WL'(N_ANDARES);

  estado_t            estado, prox;
  logic [TW-1:0]      timer;
  logic [W_ANDAR-1:0] alvo;
  logic               subindo;   // direction of the last move, consumed by ATUALIZA
  logic               conta;
  logic               le_valido;

  assign conta     = (estado == SOBE) || (estado == DESCE) || (estado == PORTA);
  assign le_valido = iniciar && !fila_vazia && !ocupado_insercao;

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado      <= OCIOSO;
      andar_atual <= '0;
      timer       <= '0;
      alvo        <= '0;
      subindo     <= 1'b0;
    end else begin
      estado <= prox;
      // The timer restarts on every state entry and only advances in the timed states.
      timer  <= (conta && (prox == estado)) ? timer + TW'(1) : '0;
      if ((estado == LE_TOPO) && le_valido)
        alvo <= andar_alvo;
      if (estado == SOBE)
        subindo <= 1'b1;
      else if (estado == DESCE)
        subindo <= 1'b0;
      if (estado == ATUALIZA)
        andar_atual <= subindo ? andar_atual + W_ANDAR'(1) : andar_atual - W_ANDAR'(1);
    end
  end

  always_comb begin
    prox         = estado;
    sobe         = 1'b0;
    desce        = 1'b0;
    porta_aberta = 1'b0;
    pop          = 1'b0;
    chegou       = 1'b0;
    erro         = 1'b0;
    Eatual_db    = estado;
    case (estado)
      OCIOSO: begin
        if (iniciar) prox = LE_TOPO;
      end
      LE_TOPO: begin
        if (!iniciar)
          prox = OCIOSO;
        else if (le_valido)
          prox = ({1'b0, andar_alvo} >= LIMITE) ? DESCARTA : COMPARA;
      end
      COMPARA: begin
        if (alvo == andar_atual) begin
          chegou = 1'b1;
          prox   = PORTA;
        end else if (alvo > andar_atual) begin
          prox = SOBE;
        end else begin
          prox = DESCE;
        end
      end
      SOBE: begin
        sobe = 1'b1;
        if (timer == FIM_ANDAR) prox = ATUALIZA;
      end
      DESCE: begin
        desce = 1'b1;
        if (timer == FIM_ANDAR) prox = ATUALIZA;
      end
      ATUALIZA: begin
        prox = LE_TOPO;
      end
      PORTA: begin
        porta_aberta = 1'b1;
        if (timer == FIM_PORTA) prox = ESPERA_REMOVE;
      end
      ESPERA_REMOVE: begin
        if (!ocupado_insercao) prox = POP;
      end
      POP: begin
        pop  = 1'b1;
        prox = LE_TOPO;
      end
      DESCARTA: begin
        erro = 1'b1;
        prox = ESPERA_REMOVE;
      end
      default: prox = OCIOSO;
    endcase
  end

endmodule

// File: doc/uc_atende_fila.md
# uc_atende_fila

Service control unit for the PoLift cargo lift. Consumes the floor-request queue kept in the request RAM, whose top entry is maintained by the new-request insertion unit. It moves the car floor by floor toward the current top entry, re-reading the top after every floor so that requests inserted en route are honoured. At each target it holds the door open, then pops the entry through a one-cycle handshake that never collides with an in-progress insertion.

## Interface
- W_ANDAR, 4, width of floor numbers
- N_ANDARES, 8, number of valid floors (0..N_ANDARES-1)
- T_ANDAR, 50, clock cycles per one-floor move
- T_PORTA, 100, clock cycles the door stays open
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low (0 = reset, sampled on rising edge of clock)
- iniciar  in  1  level enable for servicing
- fila_vazia  in  1  1 = request RAM holds no entries
- andar_alvo  in  W_ANDAR  floor in the top RAM entry
- ocupado_insercao  in  1  1 = insertion unit is mid-operation (RAM busy)
- andar_atual  out  W_ANDAR  current car floor (registered)
- sobe  out  1  motor up
- desce  out  1  motor down
- porta_aberta  out  1  door open
- pop  out  1  one-cycle pulse: remove top RAM entry
- chegou  out  1  one-cycle pulse on arrival at target
- erro  out  1  one-cycle pulse: invalid target discarded
- Eatual_db  out  4  current state code, for debug

## Operation
- **States:** OCIOSO(0), LE_TOPO(1), COMPARA(2), SOBE(3), DESCE(4), ATUALIZA(5), PORTA(6), ESPERA_REMOVE(7), POP(8), DESCARTA(9). Codes 10–15 go to OCIOSO.
- **OCIOSO:** move to LE_TOPO when iniciar=1.
- **LE_TOPO:**
  - iniciar=0 → OCIOSO.
  - fila_vazia=1 or ocupado_insercao=1 → stay.
  - Otherwise latch andar_alvo into the internal target register.
    - Latched value ≥ N_ANDARES → DESCARTA.
    - Otherwise → COMPARA.
- **COMPARA:**
  - target == andar_atual → PORTA, with chegou=1 for this cycle.
  - target > andar_atual → SOBE.
  - target < andar_atual → DESCE.
- **SOBE / DESCE:**
  - sobe (or desce) is held high.
  - The timer counts 0..T_ANDAR-1; at the terminal count → ATUALIZA.
  - The timer clears on every state entry.
- **ATUALIZA:**
  - andar_atual is incremented if arriving from SOBE, decremented if from DESCE.
  - Then → LE_TOPO, so the target is re-read after every floor.
- **PORTA:** porta_aberta=1 for T_PORTA cycles, then → ESPERA_REMOVE.
- **ESPERA_REMOVE:** stay while ocupado_insercao=1; otherwise → POP.
- **POP:** pop=1 for exactly one cycle, then → LE_TOPO.
- **DESCARTA:** erro=1 for one cycle, then → ESPERA_REMOVE.
- **iniciar:** sampled only in OCIOSO and LE_TOPO. Deasserting it mid-move or with the door open completes the current floor / door / pop sequence first.
- **Floor range:** andar_atual never leaves 0..N_ANDARES-1, because an invalid target never enters COMPARA.
- **Output decode:** all outputs are Moore-decoded from the state; sobe and desce are never both high.

## Timing
- **Reset:**
  - state = OCIOSO, andar_atual = 0, timer = 0, target register = 0.
  - sobe, desce, porta_aberta, pop, chegou, erro all 0.
  - Eatual_db = 0.
  - Reset mid-move aborts immediately; the floor returns to 0. This is a simulation model only; the physical car is not modelled.
- **Per floor moved:** T_ANDAR + 3 cycles (SOBE/DESCE + ATUALIZA + LE_TOPO + COMPARA).
- **Already at target:** from LE_TOPO with a valid entry, pop asserts after 1 (LE_TOPO) + 1 (COMPARA) + T_PORTA + 1 (ESPERA_REMOVE) cycles, assuming ocupado_insercao=0.
- **pop handshake:** the queue must present the new top (or fila_vazia) by the next LE_TOPO cycle, which is one cycle after pop.
- **Simultaneous events:**
  - fila_vazia=0 together with ocupado_insercao=1 in LE_TOPO: wait. The top entry may be changing.
  - ocupado_insercao rising in the same cycle ESPERA_REMOVE is entered: wait.
  - pop is never high while ocupado_insercao=1 was sampled high in the previous state.

## Test plan
1. **Reset:** hold reset=0 for 2 edges during SOBE → next cycle all outputs 0, andar_atual=0, Eatual_db=0.
2. **Move up (T_ANDAR=4, T_PORTA=3):** andar_alvo=3, fila_vazia=0 → sobe high for 3 runs of 4 cycles; andar_atual steps 1,2,3; chegou one pulse; porta_aberta 3 cycles; single pop pulse; then waits in LE_TOPO with fila_vazia=1.
3. **Same-floor request:** andar_alvo=0 at floor 0 → no sobe/desce; chegou, porta_aberta 3 cycles, pop exactly 6 cycles after entering LE_TOPO.
4. **Retarget en route:** target 5 from floor 0; after andar_atual=1, top changes to 2 → car stops at 2, door opens, and only that entry is popped; next read resumes toward 5.
5. **Blocked pop:** ocupado_insercao=1 for 5 cycles covering ESPERA_REMOVE → pop asserts one cycle after it drops, width 1.
6. **Invalid target:** andar_alvo=9 with N_ANDARES=8 → erro one pulse, pop one pulse, no motion, andar_atual unchanged. Then a descending request 2 from floor 3 → desce for 4 cycles, andar_atual=2.
